// File: rtl/simon_pkg.sv
// simon_pkg: shared types and constants for the Simon game datapath.
//   colour_t    - 2-bit colour code produced by the RNG and the buttons
//   chk_state_t - state encoding of the sequence checker FSM
//   SEQ_DEPTH   - maximum stored sequence length
package simon_pkg;

  localparam int SEQ_DEPTH = 32;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } colour_t;

  typedef enum logic [2:0] {
    CHK_IDLE,
    CHK_WAIT_PRESS,
    CHK_READ,
    CHK_COMPARE,
    CHK_FAIL,
    CHK_DONE
  } chk_state_t;

endpackage

// File: rtl/seq_ram.sv
// seq_ram: DEPTH x COLOUR_W colour store, one write port and one
// registered (synchronous) read port. The array has no reset; only the
// read data register updates when re is high.
//   clk   in   clock
//   we    in   write enable
//   waddr in   write address
//   wdata in   write data
//   re    in   read enable
//   raddr in   read address
//   rdata out  read data, valid the cycle after re
module seq_ram import simon_pkg::*; #(
  parameter int DEPTH    = SEQ_DEPTH,
  parameter int COLOUR_W = 2,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [COLOUR_W-1:0] wdata,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [COLOUR_W-1:0] rdata
);

  logic [COLOUR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/seq_checker.sv
// seq_checker: Simon sequence store and player-input checker.
// Appends RNG colours on load_colour while idle, then during player_turn
// compares each debounced press against the stored sequence for the
// requested round and reports the verdict on result/empty.
//   clk, rst        clock, synchronous active-high reset
//   start           new game: clears the stored sequence
//   load_colour     append colour_in (idle and not full only)
//   colour_in       colour from the RNG
//   player_turn     level, high while the player enters the sequence
//   check_round     round r requires r+1 presses
//   btn_valid       one-cycle press strobe, btn_colour valid with it
//   result          1 = all presses so far matched
//   empty           1 = no further presses expected this turn
//   seq_len, full   stored length and length == DEPTH
module seq_checker import simon_pkg::*; #(
  parameter int DEPTH    = SEQ_DEPTH,
  parameter int COLOUR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                load_colour,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                player_turn,
  input  logic [4:0]          check_round,
  input  logic                btn_valid,
  input  logic [COLOUR_W-1:0] btn_colour,
  output logic                result,
  output logic                empty,
  output logic [5:0]          seq_len,
  output logic                full
);

  localparam int AW = $clog2(DEPTH);

  chk_state_t          state_q, state_d;
  logic [5:0]          seq_len_q, seq_len_d;
  logic [5:0]          target_q, target_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [COLOUR_W-1:0] btn_q, btn_d;
  logic                result_q, result_d;
  logic                empty_q, empty_d;
  logic                pt_q;

  logic                pt_rise, load_ok, ram_re;
  logic [5:0]          tgt_new, ptr_inc;
  logic [COLOUR_W-1:0] rd_data;

  assign full    = (seq_len_q == 6'(DEPTH));
  assign pt_rise = player_turn & ~pt_q;
  assign tgt_new = {1'b0, check_round} + 6'd1;
  assign ptr_inc = 6'(rd_ptr_q) + 6'd1;
  // Sequence may only grow between turns; start takes priority.
  assign load_ok = load_colour & ~start & ~full & (state_q == CHK_IDLE);

  always_comb begin
    seq_len_d = seq_len_q;
    if (start)        seq_len_d = 6'd0;
    else if (load_ok) seq_len_d = seq_len_q + 6'd1;
  end

  seq_ram #(.DEPTH(DEPTH), .COLOUR_W(COLOUR_W), .AW(AW)) u_ram (
    .clk  (clk),
    .we   (load_ok),
    .waddr(seq_len_q[AW-1:0]),
    .wdata(colour_in),
    .re   (ram_re),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CHK_IDLE;
      seq_len_q <= 6'd0;
      target_q <= 6'd0;
      rd_ptr_q <= '0;
      btn_q    <= '0;
      result_q <= 1'b0;
      empty_q  <= 1'b1;
      pt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_len_q <= seq_len_d;
      target_q <= target_d;
      rd_ptr_q <= rd_ptr_d;
      btn_q    <= btn_d;
      result_q <= result_d;
      empty_q  <= empty_d;
      pt_q     <= player_turn;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    rd_ptr_d = rd_ptr_q;
    btn_d    = btn_q;
    result_d = result_q;
    empty_d  = empty_q;
    ram_re   = 1'b0;
    unique case (state_q)
      CHK_IDLE: begin
        if (pt_rise) begin
          target_d = tgt_new;
          if (tgt_new > seq_len_q) begin
            result_d = 1'b0;
            empty_d  = 1'b1;
            state_d  = CHK_FAIL;
          end else begin
            rd_ptr_d = '0;
            result_d = 1'b1;
            empty_d  = 1'b0;
            state_d  = CHK_WAIT_PRESS;
          end
        end
      end
      CHK_WAIT_PRESS: begin
        if (!player_turn) begin
          empty_d = 1'b1;
          state_d = CHK_IDLE;
        end else if (btn_valid) begin
          btn_d   = btn_colour;
          ram_re  = 1'b1;
          state_d = CHK_READ;
        end
      end
      CHK_READ: begin
        if (!player_turn) begin
          empty_d = 1'b1;
          state_d = CHK_IDLE;
        end else begin
          state_d = CHK_COMPARE;
        end
      end
      CHK_COMPARE: begin
        if (!player_turn) begin
          empty_d = 1'b1;
          state_d = CHK_IDLE;
        end else if (rd_data != btn_q) begin
          result_d = 1'b0;
          empty_d  = 1'b1;
          state_d  = CHK_FAIL;
        end else if (ptr_inc == target_q) begin
          // Last press of the round; pointer is left alone so it never wraps.
          empty_d = 1'b1;
          state_d = CHK_DONE;
        end else begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          state_d  = CHK_WAIT_PRESS;
        end
      end
      CHK_FAIL, CHK_DONE: begin
        if (!player_turn) state_d = CHK_IDLE;
      end
      default: state_d = CHK_IDLE;
    endcase
  end

  assign result  = result_q;
  assign empty   = empty_q;
  assign seq_len = seq_len_q;

endmodule

// File: tb/tb_seq_checker.sv
module tb_seq_checker;
  import simon_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, load_colour, player_turn, btn_valid;
  logic [1:0] colour_in, btn_colour;
  logic [4:0] check_round;
  logic       result, empty, full;
  logic [5:0] seq_len;

  int total = 0;
  int bad   = 0;
  logic [1:0] pat [33];

  seq_checker #(.DEPTH(32), .COLOUR_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .load_colour(load_colour),
    .colour_in(colour_in), .player_turn(player_turn), .check_round(check_round),
    .btn_valid(btn_valid), .btn_colour(btn_colour), .result(result),
    .empty(empty), .seq_len(seq_len), .full(full)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [1:0] c);
    load_colour = 1'b1; colour_in = c; tick(); load_colour = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic press(input logic [1:0] c);
    btn_valid = 1'b1; btn_colour = c; tick(); btn_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    total++;
    if ({result, empty, full, seq_len} !== {1'b0, 1'b1, 1'b0, 6'd0}) begin
      bad++; $display("FAIL reset got r=%0b e=%0b f=%0b len=%0d exp r=0 e=1 f=0 len=0",
                      result, empty, full, seq_len);
    end
  endtask

  task automatic test_round0();
    do_start();
    load(GREEN);
    total++;
    if (seq_len !== 6'd1) begin bad++; $display("FAIL r0_len got=%0d exp=1", seq_len); end
    check_round = 5'd0; player_turn = 1'b1; tick();
    total++;
    if ({result, empty} !== 2'b10) begin bad++; $display("FAIL r0_rise got=%b exp=10", {result, empty}); end
    press(GREEN); tick();
    total++;
    if ({result, empty} !== 2'b10) begin bad++; $display("FAIL r0_press_n2 got=%b exp=10", {result, empty}); end
    tick();
    total++;
    if ({result, empty} !== 2'b11) begin bad++; $display("FAIL r0_press_n3 got=%b exp=11", {result, empty}); end
    player_turn = 1'b0; tick();
    total++;
    if ({result, empty} !== 2'b11) begin bad++; $display("FAIL r0_hold got=%b exp=11", {result, empty}); end
  endtask

  task automatic test_mismatch();
    do_start();
    load(RED); load(GREEN); load(BLUE);
    check_round = 5'd2; player_turn = 1'b1; tick();
    total++;
    if ({result, empty} !== 2'b10) begin bad++; $display("FAIL mm_rise got=%b exp=10", {result, empty}); end
    press(RED); tick(); tick();
    total++;
    if ({result, empty} !== 2'b10) begin bad++; $display("FAIL mm_first got=%b exp=10", {result, empty}); end
    press(YELLOW); tick(); tick();
    total++;
    if ({result, empty} !== 2'b01) begin bad++; $display("FAIL mm_wrong got=%b exp=01", {result, empty}); end
    press(BLUE); tick(); tick();
    total++;
    if ({result, empty} !== 2'b01) begin bad++; $display("FAIL mm_ignored got=%b exp=01", {result, empty}); end
    player_turn = 1'b0; tick();
  endtask

  task automatic test_insufficient();
    do_start();
    load(RED); load(GREEN);
    total++;
    if (seq_len !== 6'd2) begin bad++; $display("FAIL ins_len got=%0d exp=2", seq_len); end
    check_round = 5'd4; player_turn = 1'b1; tick();
    total++;
    if ({result, empty} !== 2'b01) begin bad++; $display("FAIL ins_verdict got=%b exp=01", {result, empty}); end
    player_turn = 1'b0; tick();
  endtask

  task automatic test_full();
    do_start();
    for (int i = 0; i < 32; i++) pat[i] = 2'((i * 3 + 1) % 4);
    pat[32] = pat[0] ^ 2'b11;
    for (int i = 0; i < 33; i++) load(pat[i]);
    total++;
    if ({full, seq_len} !== {1'b1, 6'd32}) begin
      bad++; $display("FAIL full_len got f=%0b len=%0d exp f=1 len=32", full, seq_len);
    end
    check_round = 5'd31; player_turn = 1'b1; tick();
    total++;
    if ({result, empty} !== 2'b10) begin bad++; $display("FAIL full_rise got=%b exp=10", {result, empty}); end
    for (int i = 0; i < 32; i++) begin
      press(pat[i]); tick(); tick();
      total++;
      if ({result, empty} !== {1'b1, (i == 31)}) begin
        bad++; $display("FAIL full_press%0d got=%b exp=%b", i, {result, empty}, {1'b1, (i == 31)});
      end
    end
    player_turn = 1'b0; tick();
  endtask

  task automatic test_abort_reset();
    do_start();
    load(BLUE); load(RED); load(YELLOW); load(GREEN); load(RED);
    check_round = 5'd4; player_turn = 1'b1; tick();
    press(BLUE); tick(); tick();
    total++;
    if ({result, empty} !== 2'b10) begin bad++; $display("FAIL ab_mid got=%b exp=10", {result, empty}); end
    player_turn = 1'b0; tick();
    total++;
    if ({result, empty} !== 2'b11) begin bad++; $display("FAIL ab_abort got=%b exp=11", {result, empty}); end
    check_round = 5'd0; player_turn = 1'b1; tick();
    total++;
    if ({result, empty} !== 2'b10) begin bad++; $display("FAIL ab_restart got=%b exp=10", {result, empty}); end
    press(BLUE); tick(); tick();
    total++;
    if ({result, empty} !== 2'b11) begin bad++; $display("FAIL ab_done got=%b exp=11", {result, empty}); end
    total++;
    if (seq_len !== 6'd5) begin bad++; $display("FAIL ab_len got=%0d exp=5", seq_len); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if ({result, empty, full, seq_len} !== {1'b0, 1'b1, 1'b0, 6'd0}) begin
      bad++; $display("FAIL ab_rst got r=%0b e=%0b f=%0b len=%0d exp r=0 e=1 f=0 len=0",
                      result, empty, full, seq_len);
    end
    player_turn = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    do_start();
    load(RED); load(RED);
    start = 1'b1; load_colour = 1'b1; colour_in = YELLOW; tick();
    start = 1'b0; load_colour = 1'b0;
    total++;
    if (seq_len !== 6'd0) begin bad++; $display("FAIL b2b_start_wins got=%0d exp=0", seq_len); end
    load(GREEN); load(BLUE);
    check_round = 5'd1; player_turn = 1'b1; tick();
    press(GREEN);
    press(BLUE);   // lands in READ, must be dropped
    tick();
    total++;
    if ({result, empty} !== 2'b10) begin bad++; $display("FAIL b2b_early_drop got=%b exp=10", {result, empty}); end
    press(BLUE); tick(); tick();
    total++;
    if ({result, empty} !== 2'b11) begin bad++; $display("FAIL b2b_second got=%b exp=11", {result, empty}); end
    player_turn = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load_colour = 1'b0; colour_in = '0;
    player_turn = 1'b0; check_round = '0; btn_valid = 1'b0; btn_colour = '0;
    tick();
    test_reset();
    test_round0();
    test_mismatch();
    test_insufficient();
    test_full();
    test_abort_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
